// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU. It keeps one operation in flight.
// Optional per-requester grant counters are built when ALU_ARB_PERF_EN is defined.
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [5:0]        r0_ctrl,
    input  logic [31:0]       r0_a,
    input  logic [31:0]       r0_b,
    output logic              r0_rsp_valid,
    input  logic              r0_rsp_ready,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [5:0]        r1_ctrl,
    input  logic [31:0]       r1_a,
    input  logic [31:0]       r1_b,
    output logic              r1_rsp_valid,
    input  logic              r1_rsp_ready,
    output logic [31:0]       rsp_result,
    output logic              rsp_branch,
    output logic [5:0]        alu_ctrl,
    output logic              alu_branch_op,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    input  logic [31:0]       alu_result,
    input  logic              alu_branch,
    output logic              busy,
`ifdef ALU_ARB_PERF_EN
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1,
`endif
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        ptr;
    logic        owner;
    logic [5:0]  ctrl_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] res_q;
    logic        br_q;
    logic        grant0;
    logic        grant1;
    logic        owner_rsp_ready;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Requests hold valid until accepted. Responses hold valid and data until rsp_ready.
    assign grant0 = r0_valid & (~r1_valid | ~ptr);
    assign grant1 = r1_valid & (~r0_valid | ptr);

    assign r0_ready        = (state == IDLE) & grant0;
    assign r1_ready        = (state == IDLE) & grant1;
    assign r0_rsp_valid    = (state == RESP) & ~owner;
    assign r1_rsp_valid    = (state == RESP) & owner;
    assign owner_rsp_ready = owner ? r1_rsp_ready : r0_rsp_ready;

    assign rsp_result    = res_q;
    assign rsp_branch    = br_q;
    assign alu_ctrl      = ctrl_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign alu_branch_op = (ctrl_q[4:3] == 2'b10);
    assign busy          = (state != IDLE);
    assign state_dbg     = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            owner  <= 1'b0;
            ctrl_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            br_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 | grant1) begin
                        ctrl_q <= grant1 ? r1_ctrl : r0_ctrl;
                        a_q    <= grant1 ? r1_a : r0_a;
                        b_q    <= grant1 ? r1_b : r0_b;
                        owner  <= grant1;
                        // The pointer favours whichever requester did not just win.
                        ptr    <= ~grant1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    res_q <= alu_result;
                    br_q  <= alu_branch;
                    state <= RESP;
                end
                RESP: begin
                    if (owner_rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (r0_valid && r0_ready && (grant_cnt0 != {CNT_W{1'b1}})) begin
                grant_cnt0 <= grant_cnt0 + 1'b1;
            end
            if (r1_valid && r1_ready && (grant_cnt1 != {CNT_W{1'b1}})) begin
                grant_cnt1 <= grant_cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter CNT_W, default 16: width of each per-requester grant counter (Configuration only).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 rN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 rN_ctrl  input  6  ALU control word of requester N.
REQ-007 rN_a, rN_b  input  32 each  operands A and B of requester N.
REQ-008 rN_rsp_valid  output  1  result for requester N is valid.
REQ-009 rN_rsp_ready  input  1  requester N consumes its result.
REQ-010 rsp_result  output  32  shared result bus.
REQ-011 rsp_branch  output  1  shared branch-taken bus.
REQ-012 alu_ctrl  output  6  control word to the shared ALU.
REQ-013 alu_branch_op  output  1  branch-op flag to the ALU.
REQ-014 alu_a, alu_b  output  32 each  operands to the ALU.
REQ-015 alu_result  input  32  ALU result (combinational).
REQ-016 alu_branch  input  1  ALU branch-taken (combinational).
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states: IDLE, EXEC, RESP; one transaction in flight.
REQ-019 IDLE: if any rN_valid, grant one; rN_ready = (state==IDLE) & grant_N, combinational; at most one ready high.
REQ-020 Arbitration: one valid wins; both valid -> round-robin pointer picks; pointer moves to the other requester after every grant.
REQ-021 Accept edge (valid&ready): ctrl, a, b and owner ID are registered; IDLE->EXEC.
REQ-022 ALU ports always driven from the operand registers, so they hold their last value outside EXEC.
REQ-023 alu_branch_op = (registered ctrl[4:3] == 2'b10).
REQ-024 EXEC (exactly one cycle): alu_result/alu_branch captured into rsp registers; EXEC->RESP.
REQ-025 RESP: r<owner>_rsp_valid=1, the other rsp_valid=0; rsp_result/rsp_branch stable until handshake.
REQ-026 Owner's rsp_ready high in RESP -> RESP->IDLE next edge; low -> stay RESP indefinitely.
REQ-027 New requests in EXEC/RESP are not accepted (ready=0) and stay pending; no request is dropped.
REQ-028 Latency: accept edge T, rsp_valid high from cycle T+2; minimum issue interval 3 cycles.
REQ-029 rsp_ready of the non-owner and in IDLE/EXEC is ignored.

Reset
REQ-030 Reset: state=IDLE, pointer=requester 0, operand/ctrl/rsp registers=0, all rsp_valid=0, busy=0.
REQ-031 Reset mid-EXEC/RESP aborts the transaction; no response is delivered for it.

Configuration
REQ-032 Macro ALU_ARB_PERF_EN defined: outputs grant_cnt0, grant_cnt1 (CNT_W each) count accept handshakes per requester, saturate at all-ones, clear on reset.
REQ-033 ALU_ARB_PERF_EN undefined: counters and their ports absent; all other behaviour identical.

Verification
REQ-034 Reset, r0 issues ctrl=6'b000000, a=5, b=7 -> r0_rsp_valid 2 cycles after accept, rsp_result=12, rsp_branch=0.
REQ-035 r0,r1 valid same cycle after reset -> r0 granted first, r1 next; repeat -> r0 then r1 alternate.
REQ-036 r1 issues ctrl=6'b010000 (BEQ), a=b=3 -> alu_branch_op=1, rsp_branch=1, rsp_result=0.
REQ-037 Owner holds rsp_ready=0 for 5 cycles with r0_valid high -> result stable, busy=1, r0_ready=0 throughout; accept resumes after handshake.
REQ-038 Reset asserted in EXEC -> next cycle IDLE, all rsp_valid=0, no response for aborted op.
REQ-039 With ALU_ARB_PERF_EN, CNT_W=2, five r0 grants -> grant_cnt0=3 (saturated), grant_cnt1=0.
